// File: rtl/bus_arbiter_mux_pkg.sv
// Shared types for the registered CPU bus multiplexer/arbiter: mode encoding,
// FSM states and the legacy source slot numbering.
package bus_arbiter_mux_pkg;

  typedef enum logic {
    ARB_DIRECT = 1'b0,
    ARB_RR     = 1'b1
  } arb_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Legacy source slots; R0..R15 occupy indices 0..15.
  localparam int SRC_R0     = 0;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CVAL   = 23;

endpackage

// File: rtl/bus_arbiter_mux_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping from NSRC-1 back to 0 (ptr itself is scanned last).
module bus_arbiter_mux_rr_pick #(
  parameter int NSRC = 24,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [2*NSRC-1:0] dbl;
  logic [NSRC-1:0]   rot;
  int                off;
  int                idx_int;

  always_comb begin
    dbl     = {req, req} >> (int'(ptr) + 1);
    rot     = dbl[NSRC-1:0];
    found   = 1'b0;
    off     = 0;
    // Scan from the far end so the nearest requester is the last one written.
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    idx_int = (int'(ptr) + 1 + off) % NSRC;
    idx     = SELW'(idx_int);
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus driver: direct encoded select or round-robin arbitration
// with bus locking; unpopulated/out-of-range selects raise sel_err instead of X.
module bus_arbiter_mux
  import bus_arbiter_mux_pkg::*;
#(
  parameter int              WIDTH       = 32,
  parameter int              NSRC        = 24,
  parameter int              SELW        = $clog2(NSRC),
  parameter logic [NSRC-1:0] UNUSED_MASK = 24'h40_0000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic              arb_en,
  input  logic [SELW-1:0]   sel,
  input  logic              sel_vld,
  input  logic [NSRC-1:0]   req,
  input  logic              lock,
  output logic [NSRC-1:0]   grant,
  output logic [WIDTH-1:0]  bus_out,
  output logic              bus_vld,
  output logic              sel_err,
  output logic [1:0]        fsm_state
);

  logic [WIDTH-1:0] src_w [NSRC];
  state_e           state;
  arb_mode_e        mode;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  owner;
  logic [NSRC-1:0]  req_legal;
  logic             pick_found;
  logic [SELW-1:0]  pick_idx;
  logic             keep;
  logic             sel_legal;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] pick_word;
  logic [WIDTH-1:0] owner_word;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_w[i] = src_data[i*WIDTH +: WIDTH];
  end

  assign mode      = arb_mode_e'(arb_en);
  assign req_legal = req & ~UNUSED_MASK;
  assign fsm_state = state;
  // grant is one-hot of owner, so this tests req[owner] without a wide index.
  assign keep      = (state == ST_LOCKED) && lock && (|(grant & req));

  bus_arbiter_mux_rr_pick #(
    .NSRC (NSRC),
    .SELW (SELW)
  ) u_rr_pick (
    .req   (req_legal),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Compare-based muxes keep out-of-range codes (e.g. 24..31) from indexing src_w.
  always_comb begin
    sel_legal  = 1'b0;
    sel_word   = '0;
    pick_word  = '0;
    owner_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) begin
        sel_legal = ~UNUSED_MASK[i];
        sel_word  = src_w[i];
      end
      if (pick_idx == SELW'(i)) pick_word = src_w[i];
      if (owner == SELW'(i)) owner_word = src_w[i];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= SELW'(NSRC - 1);
      owner   <= '0;
      grant   <= '0;
      bus_out <= '0;
      bus_vld <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      case (mode)
        ARB_DIRECT: begin
          state   <= ST_IDLE;
          grant   <= '0;
          sel_err <= sel_vld && !sel_legal;
          bus_vld <= sel_vld && sel_legal;
          if (sel_vld && sel_legal) bus_out <= sel_word;
        end
        default: begin
          sel_err <= 1'b0;
          if (keep) begin
            state   <= ST_LOCKED;
            bus_out <= owner_word;
            bus_vld <= 1'b1;
          end else if (pick_found) begin
            state   <= lock ? ST_LOCKED : ST_OWNED;
            owner   <= pick_idx;
            rr_ptr  <= pick_idx;
            grant   <= NSRC'(1) << pick_idx;
            bus_out <= pick_word;
            bus_vld <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            grant   <= '0;
            bus_vld <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: driver pushes hand-computed expectations,
// a posedge monitor pops and compares the registered outputs.
module tb_bus_arbiter_mux;

  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int SELW  = 5;
  localparam int EW    = WIDTH + 1 + 1 + NSRC + 2;

  logic                  clk;
  logic                  clr_n;
  logic [NSRC*WIDTH-1:0] src_data;
  logic                  arb_en;
  logic [SELW-1:0]       sel;
  logic                  sel_vld;
  logic [NSRC-1:0]       req;
  logic                  lock;
  logic [NSRC-1:0]       grant;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_vld;
  logic                  sel_err;
  logic [1:0]            fsm_state;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            chk_cnt;
  int            pass_cnt;

  bus_arbiter_mux #(
    .WIDTH       (WIDTH),
    .NSRC        (NSRC),
    .UNUSED_MASK (24'h40_0000)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .src_data  (src_data),
    .arb_en    (arb_en),
    .sel       (sel),
    .sel_vld   (sel_vld),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .bus_out   (bus_out),
    .bus_vld   (bus_vld),
    .sel_err   (sel_err),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] pk(input logic [WIDTH-1:0] b, input logic v,
                                       input logic e, input logic [NSRC-1:0] g,
                                       input logic [1:0] s);
    return {b, v, e, g, s};
  endfunction

  task automatic check(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else
      $display("FAIL %s: got bus=%h vld=%b err=%b gnt=%h st=%0d, want bus=%h vld=%b err=%b gnt=%h st=%0d",
               nm, act[EW-1 -: WIDTH], act[NSRC+3], act[NSRC+2], act[NSRC+1:2], act[1:0],
               exp[EW-1 -: WIDTH], exp[NSRC+3], exp[NSRC+2], exp[NSRC+1:2], exp[1:0]);
  endtask

  // driver: apply one cycle of inputs and queue the response expected after the next edge
  task automatic drive(input string nm, input logic a, input logic [SELW-1:0] s, input logic sv,
                       input logic [NSRC-1:0] r, input logic l,
                       input logic [WIDTH-1:0] e_bus, input logic e_vld, input logic e_err,
                       input logic [NSRC-1:0] e_gnt, input logic [1:0] e_st);
    @(negedge clk);
    arb_en  = a;
    sel     = s;
    sel_vld = sv;
    req     = r;
    lock    = l;
    exp_q.push_back(pk(e_bus, e_vld, e_err, e_gnt, e_st));
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string         n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, pk(bus_out, bus_vld, sel_err, grant, fsm_state), e);
    end
  end

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = 32'hC0DE_0000 | i;
    src_data[20*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    arb_en = 1'b0; sel = '0; sel_vld = 1'b0; req = '0; lock = 1'b0;
    clr_n = 1'b1;
    #3 clr_n = 1'b0;
    #2 check("reset", pk(bus_out, bus_vld, sel_err, grant, fsm_state), pk('0, 0, 0, '0, 2'd0));
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    // direct select
    drive("dir_pc",     0, 5'd20, 1, '0, 0, 32'hDEAD_BEEF, 1, 0, '0, 2'd0);
    drive("dir_ill22",  0, 5'd22, 1, '0, 0, 32'hDEAD_BEEF, 0, 1, '0, 2'd0);
    drive("dir_ill31",  0, 5'd31, 1, '0, 0, 32'hDEAD_BEEF, 0, 1, '0, 2'd0);
    drive("dir_idle",   0, 5'd20, 0, '0, 0, 32'hDEAD_BEEF, 0, 0, '0, 2'd0);
    drive("dir_r5",     0, 5'd5,  1, '0, 0, 32'hC0DE_0005, 1, 0, '0, 2'd0);

    // round robin over 3,5,9
    drive("rr_3",  1, 5'd0, 0, 24'h000228, 0, 32'hC0DE_0003, 1, 0, 24'h000008, 2'd1);
    drive("rr_5",  1, 5'd0, 0, 24'h000228, 0, 32'hC0DE_0005, 1, 0, 24'h000020, 2'd1);
    drive("rr_9",  1, 5'd0, 0, 24'h000228, 0, 32'hC0DE_0009, 1, 0, 24'h000200, 2'd1);
    drive("rr_3b", 1, 5'd0, 0, 24'h000228, 0, 32'hC0DE_0003, 1, 0, 24'h000008, 2'd1);

    // lock on 5 while 3 and 9 wait, then owner drops its request
    for (int i = 0; i < 4; i++)
      drive("lock_5", 1, 5'd0, 0, 24'h000228, 1, 32'hC0DE_0005, 1, 0, 24'h000020, 2'd2);
    drive("lock_drop", 1, 5'd0, 0, 24'h000208, 1, 32'hC0DE_0009, 1, 0, 24'h000200, 2'd2);

    // masked slot 22 and wrap to 23
    drive("mask_23",  1, 5'd0, 0, 24'hC00000, 0, 32'hC0DE_0017, 1, 0, 24'h800000, 2'd1);
    drive("mask_22",  1, 5'd0, 0, 24'h400000, 0, 32'hC0DE_0017, 0, 0, 24'h000000, 2'd0);

    // lock on 7, then reset mid-lock
    drive("lock_7a",  1, 5'd0, 0, 24'h000080, 1, 32'hC0DE_0007, 1, 0, 24'h000080, 2'd2);
    drive("lock_7b",  1, 5'd0, 0, 24'h000080, 1, 32'hC0DE_0007, 1, 0, 24'h000080, 2'd2);
    @(negedge clk);
    clr_n = 1'b0;
    #1 check("rst_midlock", pk(bus_out, bus_vld, sel_err, grant, fsm_state), pk('0, 0, 0, '0, 2'd0));
    @(negedge clk);
    clr_n = 1'b1;
    drive("post_rst_1", 1, 5'd0, 0, 24'h000082, 0, 32'hC0DE_0001, 1, 0, 24'h000002, 2'd1);
    drive("post_rst_7", 1, 5'd0, 0, 24'h000082, 0, 32'hC0DE_0007, 1, 0, 24'h000080, 2'd1);

    // back to direct mode: grant clears, bus holds
    drive("to_direct",  0, 5'd0, 0, 24'h000082, 0, 32'hC0DE_0007, 0, 0, 24'h000000, 2'd0);

    repeat (3) @(negedge clk);
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
